// File: rtl/full_adder_struct_four_pkg.sv
// Shared constants for the structural 4-bit ripple-carry adder.
// ADDER_WIDTH is the operand width that the design is built and checked at.
package full_adder_struct_four_pkg;

    localparam int ADDER_WIDTH = 4;

endpackage : full_adder_struct_four_pkg

// File: rtl/full_adder_bit.sv
// One-bit full adder made only from gate primitives.
// It uses two XOR gates, two AND gates and one OR gate.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic prop;
    logic gen;
    logic prop_carry;

    xor x_prop (prop, a, b);
    xor x_sum  (s, prop, cin);
    and a_gen  (gen, a, b);
    and a_prop (prop_carry, prop, cin);
    or  o_cout (cout, gen, prop_carry);

endmodule : full_adder_bit

// File: rtl/full_adder_struct_four.sv
// Ripple-carry adder built from full_adder_bit cells, with a registered result.
// The sum and the carry-out are captured on every rising clock edge.
module full_adder_struct_four
    import full_adder_struct_four_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign carry[0] = Cin;
    assign cout_d   = carry[WIDTH];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            full_adder_bit u_bit (
                .a    (A[gi]),
                .b    (B[gi]),
                .cin  (carry[gi]),
                .s    (sum_d[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    // Reset clears the outputs at once; it does not wait for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;

endmodule : full_adder_struct_four

// File: tb/tb_full_adder_struct_four.sv
// Bench for full_adder_struct_four. A reference model computes A+B+Cin arithmetically,
// and the DUT output is compared against it on every falling edge.
module tb_full_adder_struct_four;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] Sum;
    logic       Cout;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;
    int   exp_val  = 0;

    full_adder_struct_four #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the value captured at a rising edge is the arithmetic sum, and reset forces 0.
    always @(posedge clk) begin
        if (rst_n === 1'b1)
            exp_val = int'(A) + int'(B) + int'(Cin);
    end

    always @(negedge rst_n) exp_val = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic [4:0] want;
            want = exp_val[4:0];
            n_checks++;
            if ({Cout, Sum} !== want) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got={%b,%b} want={%b,%b}",
                         $time, Cout, Sum, want[4], want[3:0]);
            end
        end
    end

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
        @(negedge clk);
        #2;
        A   = a;
        B   = b;
        Cin = c;
    endtask

    task automatic check_lit(input string name, input logic [3:0] es, input logic ec);
        n_checks++;
        if (Sum !== es || Cout !== ec) begin
            n_fail++;
            $display("FAIL %s t=%0t got Sum=%b Cout=%b want Sum=%b Cout=%b",
                     name, $time, Sum, Cout, es, ec);
        end else begin
            $display("check %s Sum=%b Cout=%b ok", name, Sum, Cout);
        end
    endtask

    task automatic directed(input string name, input logic [3:0] a, input logic [3:0] b,
                            input logic c, input logic [3:0] es, input logic ec);
        drive(a, b, c);
        @(posedge clk);
        #1;
        check_lit(name, es, ec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t bench did not finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] v;
        rst_n = 1'b1;
        A     = 4'b1111;
        B     = 4'b1111;
        Cin   = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check_lit("reset_hold_t0", 4'b0000, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_lit("reset_hold_edge", 4'b0000, 1'b0);
        end
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_lit("reset_release", 4'b1111, 1'b1);

        directed("zero",        4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
        directed("carry_chain", 4'b0101, 4'b0101, 1'b1, 4'b1011, 1'b0);
        directed("minimal",     4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0);
        directed("maximum",     4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);
        directed("full_ripple", 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1);
        directed("mixed",       4'b1001, 4'b0110, 1'b0, 4'b1111, 1'b0);

        // Try all 512 input combinations, with an asynchronous reset pulse partway through.
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            drive(v[8:5], v[4:1], v[0]);
            if (i == 256) begin
                #1 rst_n = 1'b0;
                #1;
                check_lit("async_reset_immediate", 4'b0000, 1'b0);
                @(posedge clk);
                #1;
                check_lit("async_reset_held", 4'b0000, 1'b0);
                @(negedge clk);
                #3 rst_n = 1'b1;
                drive(v[8:5], v[4:1], v[0]);
            end
        end

        // Random inputs; sometimes the inputs change again before the clock edge.
        for (int i = 0; i < 200; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                #1;
                A   = 4'($urandom_range(0, 15));
                Cin = 1'($urandom_range(0, 1));
            end
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_full_adder_struct_four
